// File: rtl/irq_nest_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_nest_ctrl
//  Purpose  : Nesting interrupt controller that sits between peripheral
//             request lines and the cpu core. It edge-detects and latches
//             requests, picks one by fixed priority (index 0 highest), and
//             issues one-cycle take pulses with a per-source vector. A stack
//             of active sources lets only strictly higher-priority sources
//             preempt a running handler. IRET underflow and nesting overflow
//             are reported as sticky flags.
//  Ports    : i_clk / i_rst        clock, async active-high reset
//             i_irq                level request lines
//             i_mask_we/_wdata     enable-mask write port
//             i_err_clr            clears sticky error flags
//             i_int_en, i_ready    cpu global enable / ready to accept
//             i_iret               one pulse per IRET from the cpu
//             o_irq_take           one-cycle take pulse
//             o_irq_vector         vector of last taken source
//             o_in_irq, o_depth    nesting status
//             o_cur_src            source on top of the stack
//             o_pending, o_mask    latched pending bits, current mask
//             o_underflow          sticky IRET-at-depth-0 flag
//             o_overflow           sticky blocked-by-full-stack flag
//  Revision : 1.0  initial release
// ============================================================================
module irq_nest_ctrl #(
  parameter int               N_SRC      = 8,
  parameter int               DEPTH      = 4,
  parameter logic [15:0]      VEC_BASE   = 16'h0020,
  parameter logic [15:0]      VEC_STRIDE = 16'h0004,
  parameter logic [N_SRC-1:0] MASK_RST   = {N_SRC{1'b1}},
  localparam int              SW         = $clog2(N_SRC),
  localparam int              DW         = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_irq,
  input  logic             i_mask_we,
  input  logic [N_SRC-1:0] i_mask_wdata,
  input  logic             i_err_clr,
  input  logic             i_int_en,
  input  logic             i_ready,
  input  logic             i_iret,
  output logic             o_irq_take,
  output logic [15:0]      o_irq_vector,
  output logic             o_in_irq,
  output logic [DW-1:0]    o_depth,
  output logic [SW-1:0]    o_cur_src,
  output logic [N_SRC-1:0] o_pending,
  output logic [N_SRC-1:0] o_mask,
  output logic             o_underflow,
  output logic             o_overflow
);

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_TAKE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t           state_q;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q;
  logic [SW-1:0]    stack_q [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic [SW-1:0]    cur_src_q, cur_src_d;
  logic             in_irq_q;
  logic             take_q;
  logic [15:0]      vector_q;
  logic             underflow_q, overflow_q;

  logic [N_SRC-1:0] w_avail;
  logic [N_SRC-1:0] w_clr;
  logic             w_found;
  logic [SW-1:0]    w_win;
  logic             w_ovf;
  logic             w_take;
  logic             w_pop;
  logic [SW-1:0]    w_below;
  logic [15:0]      w_vector;

  always_comb begin
    w_avail = pending_q & mask_q & {N_SRC{i_int_en & i_ready}};
    w_found = 1'b0;
    w_win   = '0;
    w_ovf   = 1'b0;
    // Ascending scan keeps the lowest eligible index. A candidate that passes
    // the priority test but meets a full stack only raises the overflow flag.
    for (int k = 0; k < N_SRC; k++) begin
      if (w_avail[k] && (depth_q == '0 || SW'(k) < cur_src_q)) begin
        if (depth_q == DW'(DEPTH)) begin
          w_ovf = 1'b1;
        end else if (!w_found) begin
          w_found = 1'b1;
          w_win   = SW'(k);
        end
      end
    end

    // A take is held off while an IRET is in flight so push and pop never
    // share an edge.
    w_take   = (state_q == ST_ARB) && w_found && !i_iret;
    w_pop    = i_iret && (depth_q != '0);
    w_clr    = w_take ? ({{(N_SRC-1){1'b0}}, 1'b1} << w_win) : '0;
    w_vector = VEC_BASE + 16'(w_win) * VEC_STRIDE;

    // Entry just below the current top becomes the new top after a pop.
    w_below = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(depth_q) >= 2 && i == int'(depth_q) - 2) begin
        w_below = stack_q[i];
      end
    end

    // Set wins over the take-clear on the same bit.
    pending_d = (pending_q & ~w_clr) | (i_irq & ~prev_q);

    depth_d   = depth_q;
    cur_src_d = cur_src_q;
    if (w_take) begin
      depth_d   = depth_q + DW'(1);
      cur_src_d = w_win;
    end else if (w_pop) begin
      depth_d   = depth_q - DW'(1);
      cur_src_d = w_below;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_ARB;
      prev_q      <= '0;
      pending_q   <= '0;
      mask_q      <= MASK_RST;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
      depth_q     <= '0;
      cur_src_q   <= '0;
      in_irq_q    <= 1'b0;
      take_q      <= 1'b0;
      vector_q    <= 16'h0000;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      prev_q    <= i_irq;
      pending_q <= pending_d;
      if (i_mask_we) begin
        mask_q <= i_mask_wdata;
      end

      case (state_q)
        ST_ARB: begin
          if (w_take) begin
            state_q  <= ST_TAKE;
            take_q   <= 1'b1;
            vector_q <= w_vector;
          end
        end
        ST_TAKE: begin
          take_q  <= 1'b0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          state_q <= ST_ARB;
        end
        default: begin
          take_q  <= 1'b0;
          state_q <= ST_ARB;
        end
      endcase

      if (w_take) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == int'(depth_q)) begin
            stack_q[i] <= w_win;
          end
        end
      end
      depth_q   <= depth_d;
      cur_src_q <= cur_src_d;
      in_irq_q  <= (depth_d != '0);

      if (i_iret && depth_q == '0) begin
        underflow_q <= 1'b1;
      end else if (i_err_clr) begin
        underflow_q <= 1'b0;
      end

      if (state_q == ST_ARB && w_ovf) begin
        overflow_q <= 1'b1;
      end else if (i_err_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign o_irq_take   = take_q;
  assign o_irq_vector = vector_q;
  assign o_in_irq     = in_irq_q;
  assign o_depth      = depth_q;
  assign o_cur_src    = cur_src_q;
  assign o_pending    = pending_q;
  assign o_mask       = mask_q;
  assign o_underflow  = underflow_q;
  assign o_overflow   = overflow_q;

endmodule
`default_nettype wire

// File: doc/irq_nest_ctrl.md
# irq_nest_ctrl

- Parametrised interrupt controller placed between peripheral request lines and the `cpu` core.
- Latches up to N_SRC edge-triggered requests, arbitrates them by fixed priority and issues one-cycle `i_irq_take` pulses with a per-source vector.
- Tracks nesting up to DEPTH levels with a stack of active sources, so only strictly higher-priority sources preempt a running handler.
- Guards against IRET underflow and nesting overflow, and reports both as sticky flags.

## Interface
Parameters:
- N_SRC, 8, number of request sources (≥2); index 0 is highest priority.
- DEPTH, 4, maximum nesting levels (≥1).
- VEC_BASE, 16'h0020, vector of source 0.
- VEC_STRIDE, 16'h0004, vector spacing between sources.
- MASK_RST, all ones, reset value of the enable mask.

Ports (SW = $clog2(N_SRC), DW = $clog2(DEPTH+1)):
- i_clk  in  1  clock; all state on rising edge.
- i_rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- i_irq  in  N_SRC  level request lines, edge-detected internally.
- i_mask_we  in  1  write enable for mask.
- i_mask_wdata  in  N_SRC  new mask value.
- i_err_clr  in  1  clears sticky error flags.
- i_int_en  in  1  global enable from cpu `o_int_en`.
- i_ready  in  1  cpu can accept an interrupt this cycle.
- i_iret  in  1  cpu `o_iret_detected`, one pulse per IRET.
- o_irq_take  out  1  one-cycle take pulse to cpu `i_irq_take`.
- o_irq_vector  out  16  vector to cpu `i_irq_vector`; held until next take.
- o_in_irq  out  1  depth ≠ 0.
- o_depth  out  DW  current nesting depth.
- o_cur_src  out  SW  source on top of stack; 0 when depth = 0.
- o_pending  out  N_SRC  latched pending bits.
- o_mask  out  N_SRC  current mask.
- o_underflow  out  1  sticky: IRET seen at depth 0.
- o_overflow  out  1  sticky: eligible request blocked because depth = DEPTH.

## Operation
- Edge detect: prev register per line, reset 0. Rising edge (i_irq=1, prev=0) sets pending[k]. A line held high through reset release counts as an edge.
- Pending clear: pending[k] clears on the take of k. If a set and a clear hit the same bit in one cycle, set wins.
- Mask: on i_mask_we, o_mask ← i_mask_wdata. Masked sources still latch pending.
- Eligibility of k, all required:
  - pending[k] and mask[k];
  - i_int_en and i_ready;
  - depth < DEPTH;
  - depth = 0 or k < o_cur_src.
- The winner is the lowest eligible index.
- FSM states:
  - ARB: if no i_iret this cycle and a winner exists → TAKE. Push winner, depth+1, clear pending[winner], o_irq_vector ← VEC_BASE + winner·VEC_STRIDE (16-bit wraparound).
  - TAKE: o_irq_take = 1 for exactly this cycle → WAIT.
  - WAIT: one lockout cycle → ARB.
- IRET: accepted in any state. If depth > 0: pop, depth−1, o_cur_src ← new top (0 if empty). If depth = 0: ignored, depth stays 0, o_underflow ← 1.
- Push and pop never fall on the same edge, because ARB suppresses a take when i_iret is high.
- o_overflow ← 1 in any ARB cycle where a request would be eligible except that depth = DEPTH.
- i_err_clr clears both sticky flags. If a set condition occurs in the same cycle, set wins.

## Timing
- Reset values:
  - o_irq_take 0, o_irq_vector 16'h0000, o_in_irq 0, o_depth 0, o_cur_src 0;
  - o_pending 0, o_mask MASK_RST, o_underflow 0, o_overflow 0;
  - FSM in ARB.
- Reset is asynchronous: asserting i_rst mid-handler drops o_irq_take and the whole stack in the same cycle.
- Latency: rising edge sampled at edge E0 → pending at E0 → state TAKE, o_irq_take = 1, depth+1 at E1 → o_irq_take = 0 at E2 → ARB at E3.
- Minimum spacing between two takes: 3 cycles.
- o_depth, o_in_irq and o_cur_src update on the same edge that raises o_irq_take, and on the edge after i_iret is sampled.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Underflow guard: reset, then 4 i_iret pulses → o_depth = 0, o_in_irq = 0, o_underflow = 1. Then i_err_clr → o_underflow = 0.
- Single entry/exit: rise on i_irq[3] → exactly one o_irq_take pulse with vector 16'h002C, o_depth = 1, o_cur_src = 3. Then i_iret → o_depth = 0, o_in_irq = 0.
- Priority and preemption:
  - i_irq[5] and i_irq[2] rise together → take src 2 (vector 16'h0028).
  - Then rise i_irq[4] → no take while depth = 1, src 2 active.
  - Then rise i_irq[1] → take src 1 (16'h0024), o_depth = 2.
  - i_iret ×2 → src 4 is taken only after depth returns to 0.
- Overflow (DEPTH = 2): nest src 6 then src 3, then rise src 0 → no take, o_overflow = 1, pending[0] held. After one i_iret, src 0 is taken, o_depth = 2.
- Gating: i_int_en = 0, mask[1] = 0, or i_ready = 0 with src 1 pending → no take. Restoring all three → take within 1 cycle.
- Reset mid-handler: o_depth = 2, then assert i_rst → all outputs return to reset values immediately, with no o_irq_take glitch.
